// File: rtl/stopwatch_ctrl_60_pkg.sv
// Stopwatch shared types and digit limits.
// Used by the control top and the BCD digit cells.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int SEC_TENS_MAX = 5;
  localparam int DIGIT_MAX    = 9;
  localparam int MIN_TENS_MAX = 9;

endpackage

// File: rtl/stopwatch_ctrl_60_if.sv
// Command and display bundle of the stopwatch.
// master drives the command pulses, slave is the stopwatch.
interface stopwatch_ctrl_60_if;

  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [7:0]  sec_bcd;
  logic [7:0]  min_bcd;
  logic        running;
  logic        min_pulse;
  logic [15:0] lap_bcd;
  logic        lap_valid;

  modport master (
    output start_stop, clear, lap,
    input  sec_bcd, min_bcd, running,
    input  min_pulse, lap_bcd, lap_valid
  );

  modport slave (
    input  start_stop, clear, lap,
    output sec_bcd, min_bcd, running,
    output min_pulse, lap_bcd, lap_valid
  );

endinterface

// File: rtl/stopwatch_ctrl_60_bcd_digit.sv
// One BCD digit counting 0..MAX.
// carry flags the step that wraps MAX back to 0.
import stopwatch_pkg::*;

module bcd_digit #(
  parameter int MAX = DIGIT_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output bcd_t q,
  output logic carry
);

  logic at_max;

  assign at_max = (q == bcd_t'(MAX));
  assign carry  = en && at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= at_max ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl_60.sv
// MM:SS stopwatch with run/pause/clear and lap capture.
// Lap capture is built only when STOPWATCH_LAP_EN is defined.
import stopwatch_pkg::*;

module stopwatch_ctrl_60 #(
  parameter int TICK_DIV = 50_000_000
) (
  input logic           clk,
  input logic           rst,
  stopwatch_ctrl_60_if.slave bus
);

  localparam int PW =
    (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  state_t state, state_n;
  logic [PW-1:0] presc;
  logic tick;

  bcd_t su, st, mu, mt;
  logic c_su, c_st, c_mu;
  logic unused_c_mt;

  assign tick = (state == RUN) &&
                (presc == PW'(TICK_DIV - 1));

  always_comb begin
    state_n = state;
    if (bus.clear) begin
      state_n = IDLE;
    end else if (bus.start_stop) begin
      unique case (state)
        IDLE:    state_n = RUN;
        RUN:     state_n = PAUSE;
        PAUSE:   state_n = RUN;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // PAUSE holds the partial second; IDLE discards it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (bus.clear || state == IDLE) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  bcd_digit #(.MAX(DIGIT_MAX)) u_sec_u (
    .clk(clk), .rst(rst), .clr(bus.clear),
    .en(tick), .q(su), .carry(c_su)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_t (
    .clk(clk), .rst(rst), .clr(bus.clear),
    .en(c_su), .q(st), .carry(c_st)
  );

  bcd_digit #(.MAX(DIGIT_MAX)) u_min_u (
    .clk(clk), .rst(rst), .clr(bus.clear),
    .en(c_st), .q(mu), .carry(c_mu)
  );

  bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_t (
    .clk(clk), .rst(rst), .clr(bus.clear),
    .en(c_mu), .q(mt), .carry(unused_c_mt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.min_pulse <= 1'b0;
    end else begin
      bus.min_pulse <= c_st && !bus.clear;
    end
  end

  assign bus.sec_bcd = {st, su};
  assign bus.min_bcd = {mt, mu};
  assign bus.running = (state == RUN);

`ifdef STOPWATCH_LAP_EN
  // Captures the display as it stood before a same-cycle tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.lap_bcd   <= '0;
      bus.lap_valid <= 1'b0;
    end else if (bus.clear) begin
      bus.lap_bcd   <= '0;
      bus.lap_valid <= 1'b0;
    end else if (bus.lap && state != IDLE) begin
      bus.lap_bcd   <= {mt, mu, st, su};
      bus.lap_valid <= 1'b1;
    end
  end
`else
  logic unused_lap;
  assign unused_lap    = bus.lap;
  assign bus.lap_bcd   = '0;
  assign bus.lap_valid = 1'b0;
`endif

endmodule
